// File: rtl/fp16_pkg.sv
// Shared constants and types for the binary16 normalize/round output stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fp16_pkg;

  localparam int EXP_W   = 5;
  localparam int FRAC_W  = 10;
  localparam int BIAS    = 15;

  // Raw mantissa from the adder: carry, hidden, fraction, G, R, S.
  localparam int MANT_W  = FRAC_W + 5;
  // Normalized mantissa: hidden, fraction, G, R, S.
  localparam int NMANT_W = FRAC_W + 4;
  // Signed exponent wide enough that +1 and -lzc never wrap.
  localparam int SEXP_W  = EXP_W + 2;
  localparam int LZC_W   = 4;

  localparam logic [15:0]       QNAN    = 16'h7E00;
  localparam logic [EXP_W-1:0]  INF_EXP = 5'h1F;

  // First biased exponent that no longer fits a finite binary16 value.
  localparam logic signed [SEXP_W-1:0] EXP_OVF = SEXP_W'(2 * BIAS + 1);

  // Stage-1 payload: normalized operand plus classification tags.
  typedef struct packed {
    logic                     sign;
    logic signed [SEXP_W-1:0] exp;
    logic [NMANT_W-1:0]       mant;
    logic                     zero;
    logic                     unf;
    logic                     nan;
    logic                     inf;
  } s1_pay_t;

endpackage

// File: rtl/fp16_lzc.sv
// Leading-zero counter over the 14-bit hidden+fraction+GRS field.
// Latency: combinational.
// Backpressure: none.
// Ports: din - value to scan; cnt - number of zeros above the first 1
//        (returns NMANT_W when din is zero).
module fp16_lzc
  import fp16_pkg::*;
(
  input  logic [NMANT_W-1:0] din,
  output logic [LZC_W-1:0]   cnt
);

  // Scan from LSB upward; the highest set bit is the last to write cnt.
  always_comb begin
    cnt = LZC_W'(NMANT_W);
    for (int i = 0; i < NMANT_W; i++) begin
      if (din[i]) cnt = LZC_W'(NMANT_W - 1 - i);
    end
  end

endmodule

// File: rtl/fp16_norm_round.sv
// Normalizes the add/sub core's raw result, rounds to nearest-even and packs binary16 with flags.
// Latency: 2 cycles input-accept to out_valid, 1 result per cycle.
// Backpressure: valid/ready; outputs hold while out_valid && !out_ready, in_ready drops when both stages are full and stalled.
// Ports: clk/rst_n (sync active-low); in_* raw sign/exp/mant plus nan/inf forces;
//        out_result packed binary16 with out_ovf, out_unf, out_inexact flags.
module fp16_norm_round
  import fp16_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W:0]    in_exp,
  input  logic [MANT_W-1:0] in_mant,
  input  logic              in_nan,
  input  logic              in_inf,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_result,
  output logic              out_ovf,
  output logic              out_unf,
  output logic              out_inexact
);

  // ---------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------
  logic s1_valid;
  logic s2_adv;
  logic s1_adv;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = s2_adv || !s1_valid;
  assign in_ready = s1_adv;

  // ---------------------------------------------------------------
  // Stage 1: normalize
  // ---------------------------------------------------------------
  logic [LZC_W-1:0]         lzc;
  logic signed [SEXP_W-1:0] exp_in;
  logic signed [SEXP_W-1:0] exp_adj;
  logic [NMANT_W-1:0]       mant_adj;
  logic                     is_zero;
  s1_pay_t                  s1_d;
  s1_pay_t                  s1_q;

  fp16_lzc u_lzc (
    .din (in_mant[NMANT_W-1:0]),
    .cnt (lzc)
  );

  assign exp_in = {1'b0, in_exp};

  always_comb begin
    exp_adj  = exp_in;
    mant_adj = in_mant[NMANT_W-1:0];
    is_zero  = 1'b0;
    if (in_mant[MANT_W-1]) begin
      // Carry out of the adder: shift right, fold the dropped bit into sticky.
      mant_adj = {in_mant[MANT_W-1:2], |in_mant[1:0]};
      exp_adj  = exp_in + SEXP_W'(1);
    end else if (in_mant == '0) begin
      is_zero  = 1'b1;
    end else begin
      mant_adj = in_mant[NMANT_W-1:0] << lzc;
      exp_adj  = exp_in - $signed({{(SEXP_W-LZC_W){1'b0}}, lzc});
    end
  end

  always_comb begin
    s1_d      = '0;
    s1_d.sign = in_sign;
    s1_d.exp  = exp_adj;
    s1_d.mant = mant_adj;
    s1_d.zero = is_zero;
    // No subnormal output: any non-positive biased exponent flushes.
    s1_d.unf  = !is_zero && (exp_adj <= SEXP_W'(0));
    s1_d.nan  = in_nan;
    s1_d.inf  = in_inf;
  end

  // ---------------------------------------------------------------
  // Stage 2: round to nearest even and pack
  // ---------------------------------------------------------------
  logic [FRAC_W-1:0]        frac;
  logic                     g_bit;
  logic                     r_bit;
  logic                     s_bit;
  logic                     round_up;
  logic [FRAC_W:0]          frac_sum;
  logic signed [SEXP_W-1:0] exp_r;
  logic [15:0]              res_d;
  logic                     ovf_d;
  logic                     unf_d;
  logic                     inx_d;

  assign frac     = s1_q.mant[FRAC_W+2:3];
  assign g_bit    = s1_q.mant[2];
  assign r_bit    = s1_q.mant[1];
  assign s_bit    = s1_q.mant[0];
  assign round_up = g_bit && (r_bit || s_bit || frac[0]);
  assign frac_sum = {1'b0, frac} + (FRAC_W+1)'(round_up);
  // A carry out of the fraction leaves frac_sum[FRAC_W-1:0] at zero already.
  assign exp_r    = s1_q.exp + SEXP_W'(frac_sum[FRAC_W]);

  always_comb begin
    res_d = {s1_q.sign, exp_r[EXP_W-1:0], frac_sum[FRAC_W-1:0]};
    ovf_d = 1'b0;
    unf_d = 1'b0;
    inx_d = g_bit | r_bit | s_bit;
    if (s1_q.nan) begin
      res_d = QNAN;
      inx_d = 1'b0;
    end else if (s1_q.inf) begin
      res_d = {s1_q.sign, INF_EXP, {FRAC_W{1'b0}}};
      inx_d = 1'b0;
    end else if (s1_q.zero) begin
      res_d = {s1_q.sign, 15'h0};
      inx_d = 1'b0;
    end else if (s1_q.unf) begin
      res_d = 16'h0000;
      unf_d = 1'b1;
      inx_d = 1'b1;
    end else if (exp_r >= EXP_OVF) begin
      res_d = {s1_q.sign, INF_EXP, {FRAC_W{1'b0}}};
      ovf_d = 1'b1;
      inx_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_q        <= '0;
      out_valid   <= 1'b0;
      out_result  <= 16'h0000;
      out_ovf     <= 1'b0;
      out_unf     <= 1'b0;
      out_inexact <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
        // Keep the last result on the bus when a bubble moves through.
        if (s1_valid) begin
          out_result  <= res_d;
          out_ovf     <= ovf_d;
          out_unf     <= unf_d;
          out_inexact <= inx_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp16_norm_round.sv
// Directed bench for fp16_norm_round with a queue scoreboard of hand-computed results.
// Latency: checks the 2-cycle accept-to-valid path explicitly.
// Backpressure: exercises output stall, in_ready drop and mid-stream reset flush.
module tb_fp16_norm_round;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [5:0]  in_exp;
  logic [14:0] in_mant;
  logic        in_nan;
  logic        in_inf;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic        out_ovf;
  logic        out_unf;
  logic        out_inexact;

  fp16_norm_round dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sign     (in_sign),
    .in_exp      (in_exp),
    .in_mant     (in_mant),
    .in_nan      (in_nan),
    .in_inf      (in_inf),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_ovf     (out_ovf),
    .out_unf     (out_unf),
    .out_inexact (out_inexact)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        nan;
    logic        inf;
    logic        sign;
    logic [5:0]  exp;
    logic [14:0] mant;
  } vin_t;

  localparam int NV = 21;
  vin_t        vin  [NV];
  logic [18:0] vexp [NV];   // {ovf, unf, inexact, result}
  logic [18:0] expq [$];

  int total = 0;
  int bad   = 0;
  int n_out = 0;
  int base;
  logic [15:0] hold;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, expv);
    end
  endtask

  function automatic vin_t mk(input logic nan, input logic inf, input logic sign,
                              input int e, input logic [14:0] m);
    vin_t v;
    v.nan  = nan;
    v.inf  = inf;
    v.sign = sign;
    v.exp  = 6'(e);
    v.mant = m;
    return v;
  endfunction

  function automatic logic [18:0] ex(input logic o, input logic u, input logic x, input logic [15:0] r);
    return {o, u, x, r};
  endfunction

  task automatic drive(input vin_t v);
    in_nan  = v.nan;
    in_inf  = v.inf;
    in_sign = v.sign;
    in_exp  = v.exp;
    in_mant = v.mant;
  endtask

  task automatic send(input vin_t v, input logic [18:0] e);
    int n;
    @(posedge clk); #2;
    drive(v);
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept", {31'b0, in_ready}, 1);
    if (in_ready) expq.push_back(e);
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  // Scoreboard: every output transfer must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_out++;
      chk("q_nonempty", (expq.size() > 0) ? 1 : 0, 1);
      if (expq.size() > 0)
        chk("result", {13'b0, out_ovf, out_unf, out_inexact, out_result}, {13'b0, expq.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    vin[0]  = mk(0,0,0,18,15'h4000);  vexp[0]  = ex(0,0,0,16'h4C00); // carry normalize
    vin[1]  = mk(0,0,0,17,15'h0200);  vexp[1]  = ex(0,0,0,16'h3400); // lzc=4
    vin[2]  = mk(0,0,0,15,15'h200C);  vexp[2]  = ex(0,0,1,16'h3C02); // tie, odd -> up
    vin[3]  = mk(0,0,0,15,15'h2004);  vexp[3]  = ex(0,0,1,16'h3C00); // tie, even -> stay
    vin[4]  = mk(0,0,0,30,15'h3FFC);  vexp[4]  = ex(1,0,1,16'h7C00); // round carries to overflow
    vin[5]  = mk(0,0,0,3,15'h0100);   vexp[5]  = ex(0,1,1,16'h0000); // lzc=5 -> exp -2
    vin[6]  = mk(0,0,1,10,15'h0000);  vexp[6]  = ex(0,0,0,16'h8000); // signed zero
    vin[7]  = mk(1,1,1,7,15'h1234);   vexp[7]  = ex(0,0,0,16'h7E00); // nan beats inf
    vin[8]  = mk(0,1,1,3,15'h0001);   vexp[8]  = ex(0,0,0,16'hFC00); // -inf
    vin[9]  = mk(0,0,0,15,15'h4001);  vexp[9]  = ex(0,0,1,16'h4000); // shifted-out bit -> sticky
    vin[10] = mk(0,0,0,15,15'h400C);  vexp[10] = ex(0,0,1,16'h4001); // carry shift then G&R round
    vin[11] = mk(0,0,0,20,15'h3FFE);  vexp[11] = ex(0,0,1,16'h5400); // fraction carry, exp+1
    vin[12] = mk(0,0,0,0,15'h2000);   vexp[12] = ex(0,1,1,16'h0000); // exp 0 -> underflow
    vin[13] = mk(0,0,0,31,15'h2000);  vexp[13] = ex(1,0,1,16'h7C00); // exp 31 exact -> overflow
    vin[14] = mk(0,0,0,32,15'h0008);  vexp[14] = ex(0,0,0,16'h5800); // lzc=10
    vin[15] = mk(0,0,1,1,15'h4000);   vexp[15] = ex(0,0,0,16'h8800); // negative carry
    vin[16] = mk(0,0,0,1,15'h2000);   vexp[16] = ex(0,0,0,16'h0400); // smallest normal
    vin[17] = mk(0,0,0,6,15'h0100);   vexp[17] = ex(0,0,0,16'h0400); // lzc lands on exp 1
    vin[18] = mk(0,0,0,15,15'h2003);  vexp[18] = ex(0,0,1,16'h3C00); // R,S without G
    vin[19] = mk(0,0,0,15,15'h2005);  vexp[19] = ex(0,0,1,16'h3C01); // G with S -> up
    vin[20] = mk(0,0,0,32,15'h4000);  vexp[20] = ex(1,0,1,16'h7C00); // exp 33 after carry

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive(mk(0,0,0,0,15'h0));

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ovalid", {31'b0, out_valid}, 0);
    chk("rst_result", {16'b0, out_result}, 0);
    chk("rst_flags",  {29'b0, out_ovf, out_unf, out_inexact}, 0);
    chk("rst_inrdy",  {31'b0, in_ready}, 1);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Two-cycle latency on the first vector
    @(posedge clk); #2;
    drive(vin[0]);
    in_valid = 1'b1;
    @(negedge clk);
    chk("lat_acc", {31'b0, in_ready}, 1);
    expq.push_back(vexp[0]);
    @(posedge clk); #2;
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_c1", {31'b0, out_valid}, 0);
    @(negedge clk);
    chk("lat_c2", {31'b0, out_valid}, 1);

    // Directed vectors one at a time
    for (int i = 1; i < NV; i++) send(vin[i], vexp[i]);
    repeat (4) @(negedge clk);
    chk("dir_count", n_out, NV);

    // Backpressure: three back-to-back inputs with the output stalled
    base = n_out;
    @(posedge clk); #2;
    out_ready = 1'b0;
    drive(vin[9]);
    in_valid = 1'b1;
    @(negedge clk);
    chk("bp_rdy0", {31'b0, in_ready}, 1);
    expq.push_back(vexp[9]);
    @(posedge clk); #2;
    drive(vin[10]);
    @(negedge clk);
    chk("bp_rdy1", {31'b0, in_ready}, 1);
    expq.push_back(vexp[10]);
    @(posedge clk); #2;
    drive(vin[11]);
    @(negedge clk);
    chk("bp_rdy2", {31'b0, in_ready}, 0);
    chk("bp_ovalid", {31'b0, out_valid}, 1);
    hold = out_result;
    @(posedge clk); #2;
    @(negedge clk);
    chk("bp_hold", {16'b0, out_result}, {16'b0, hold});
    chk("bp_rdy2b", {31'b0, in_ready}, 0);
    @(posedge clk); #2;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_rdy3", {31'b0, in_ready}, 1);
    expq.push_back(vexp[11]);
    @(posedge clk); #2;
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("bp_count", n_out - base, 3);

    // Reset mid-stream discards the in-flight item
    base = n_out;
    @(posedge clk); #2;
    drive(vin[14]);
    in_valid = 1'b1;
    @(negedge clk);
    chk("rs_acc", {31'b0, in_ready}, 1);
    @(posedge clk); #2;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rs_ovalid", {31'b0, out_valid}, 0);
    chk("rs_result", {16'b0, out_result}, 0);
    repeat (5) @(negedge clk);
    chk("rs_nostale", n_out - base, 0);
    chk("q_empty", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp16_norm_round.md
Name: fp16_norm_round

Overview:
- Output stage directly downstream of the half-precision add/sub core (floatingPoint).
- Consumes the core's raw result: sign, biased exponent and an extended mantissa with carry, guard, round and sticky bits.
- Produces a packed IEEE-754 binary16 word plus exception flags.
- Two-stage valid/ready pipeline: stage 1 normalizes, stage 2 rounds (round-to-nearest-even) and packs.

Parameters:
EXP_W, 5, exponent field width
FRAC_W, 10, stored fraction width
BIAS, 15, exponent bias

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  raw result valid
in_ready  out  1  stage can accept
in_sign  in  1  result sign
in_exp  in  EXP_W+1  biased exponent of the hidden-bit position (0..32)
in_mant  in  FRAC_W+5  [14]=carry, [13]=hidden, [12:3]=fraction, [2]=G, [1]=R, [0]=S
in_nan  in  1  force NaN
in_inf  in  1  force infinity with in_sign
out_valid  out  1  packed result valid
out_ready  in  1  consumer accepts
out_result  out  16  packed binary16
out_ovf  out  1  overflow to infinity
out_unf  out  1  flushed to zero
out_inexact  out  1  any G/R/S bit lost

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n). Sampled at posedge clk.
- Reset: s1_valid, s2_valid, out_valid = 0; out_result = 16'h0000; all flags = 0. An asserted reset mid-stream discards in-flight data with no output.
- Handshake:
  - Transfer occurs when valid && ready.
  - s2 advances when !s2_valid || out_ready.
  - s1 advances when s2 advances || !s1_valid.
  - in_ready = !s1_valid || s2 can advance.
  - out_* are held stable while out_valid && !out_ready.
- Latency: exactly 2 cycles from input acceptance to out_valid with no stall. Throughput is 1 per cycle. Order is preserved.
- Stage 1 (normalize):
  - If mant[14] = 1: shift right 1, OR the shifted-out bit into S, exp += 1.
  - Else if mant = 0: mark as exact zero.
  - Else: shift left by the leading-zero count of mant[13:0] so bit 13 becomes 1, exp -= lzc.
  - If the adjusted exponent is ≤ 0: mark as underflow. Subnormals are not produced.
- Stage 2 (round/pack):
  - round_up = G && (R || S || frac[0]).
  - If rounding carries out of the fraction: frac = 0, exp += 1.
  - inexact = G | R | S (after normalization).
- Priority of special cases, highest first:
  1. in_nan → 16'h7E00; all flags 0.
  2. in_inf → {sign, 5'h1F, 10'h0}; all flags 0.
  3. exact zero → {in_sign, 15'h0}; all flags 0.
  4. underflow → 16'h0000, unf = 1, inexact = 1.
  5. exp ≥ 31 after rounding → {sign, 5'h1F, 0}, ovf = 1, inexact = 1.
  6. Otherwise → {sign, exp[4:0], frac}.
- The exponent datapath is EXP_W+2 bits signed, so neither the +1 nor the −lzc adjustment can wrap.
- in_nan/in_inf bypass normalization but travel through the pipeline with the same latency.

Decomposition:
- Shared package fp16_pkg:
  - constants EXP_W, FRAC_W, BIAS
  - QNAN = 16'h7E00, INF_EXP = 5'h1F
  - typedef for the stage-1 payload: sign, exp, mant, zero/unf/nan/inf tags
- One sub-module: fp16_lzc, a combinational 14-bit leading-zero counter (4-bit output) used in stage 1.

Test Plan:
- Carry normalize: sign=0, exp=18, mant=15'b100000000000000, out_ready=1 → out_result=16'h4C00 exactly 2 cycles later; all flags 0.
- Cancellation: exp=17, mant=15'b000001000000000 (lzc=4) → 16'h3400.
- RNE:
  - exp=15, frac=10'h001, G=1, R=S=0 → 16'h3C02, inexact=1.
  - frac=10'h000, G=1, R=S=0 → 16'h3C00, inexact=1.
- Overflow: exp=30, frac=10'h3FF, G=1 → 16'h7C00, ovf=1. Underflow: exp=3, lzc=5 → 16'h0000, unf=1.
- Specials:
  - mant=0 with sign=1 → 16'h8000.
  - in_nan=1 → 16'h7E00.
  - in_inf=1 with sign=1 → 16'hFC00.
- Backpressure/reset:
  - Stream 3 inputs with out_ready=0 for 3 cycles → in_ready drops once 2 results are held; all 3 results emerge in order; none lost or duplicated.
  - rst_n=0 for 1 cycle mid-stream → out_valid=0 next cycle; no stale output afterwards.
